// File: rtl/module_mult_pkg.sv
// Shared definitions for the sign-magnitude sequential multiplier.
//   OP_W   : operand magnitude width
//   PROD_W : product magnitude width (holds 255*255 without truncation)
//   ITER   : shift-add steps per multiply, CNT_W : iteration counter width
//   state_t: controller states IDLE / CALC / DONE
package module_mult_pkg;

    localparam int unsigned OP_W   = 8;
    localparam int unsigned PROD_W = 16;
    localparam int unsigned ITER   = 8;
    localparam int unsigned CNT_W  = $clog2(ITER);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/module_mult.sv
// Sign-magnitude 8x8 sequential multiplier, radix-2 shift-add, one step per clock.
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-high reset
//   num_1    in   operand 1 magnitude        sig_1   in  operand 1 sign (1 = negative)
//   num_2    in   operand 2 magnitude        sig_2   in  operand 2 sign (1 = negative)
//   listo_1  in   operand 1 ready (level)    listo_2 in  operand 2 ready (level)
//   num_mul  out  product magnitude, registered, updated only on entry to DONE
//   sig_mul  out  product sign, registered, never set for a zero product
//   listo    out  product valid, held until either ready input drops
//   busy     out  high while the multiply iterates
module module_mult
    import module_mult_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [OP_W-1:0]     num_1,
    input  logic                sig_1,
    input  logic [OP_W-1:0]     num_2,
    input  logic                sig_2,
    input  logic                listo_1,
    input  logic                listo_2,
    output logic [PROD_W-1:0]   num_mul,
    output logic                sig_mul,
    output logic                listo,
    output logic                busy
);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PROD_W-1:0]   acc_q, acc_d;
    logic [OP_W-1:0]     mcand_q, mcand_d;
    logic [OP_W-1:0]     mplier_q, mplier_d;
    logic                sgn_q, sgn_d;
    logic [PROD_W-1:0]   num_mul_q, num_mul_d;
    logic                sig_mul_q, sig_mul_d;
    logic [PROD_W-1:0]   step;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            sgn_q     <= 1'b0;
            num_mul_q <= '0;
            sig_mul_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            sgn_q     <= sgn_d;
            num_mul_q <= num_mul_d;
            sig_mul_q <= sig_mul_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        sgn_d     = sgn_q;
        num_mul_d = num_mul_q;
        sig_mul_d = sig_mul_q;

        // Partial product for the multiplier bit selected by the counter
        step = acc_q + (mplier_q[cnt_q] ? (PROD_W'(mcand_q) << cnt_q) : '0);

        unique case (state_q)
            IDLE: begin
                if (listo_1 && listo_2) begin
                    state_d  = CALC;
                    mcand_d  = num_1;
                    mplier_d = num_2;
                    sgn_d    = sig_1 ^ sig_2;
                    acc_d    = '0;
                    cnt_d    = '0;
                end
            end
            CALC: begin
                acc_d = step;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(ITER - 1)) begin
                    state_d   = DONE;
                    num_mul_d = step;
                    // Suppress negative zero
                    sig_mul_d = sgn_q && (step != '0);
                end
            end
            DONE: begin
                // Wait for a ready input to drop so a held pair cannot re-trigger
                if (!listo_1 || !listo_2) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        num_mul = num_mul_q;
        sig_mul = sig_mul_q;
        listo   = (state_q == DONE);
        busy    = (state_q == CALC);
    end

endmodule

// File: doc/module_mult.md
MODULE_MULT -- requirements
Module: module_mult

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk clocks the block; rst is async, active-high.
REQ-002 clk  in  1  system clock; all state updates on the rising edge.
REQ-003 rst  in  1  asynchronous active-high reset.
REQ-004 num_1  in  8  magnitude of operand 1, unsigned.
REQ-005 sig_1  in  1  sign of operand 1: 1 = negative, 0 = positive.
REQ-006 num_2  in  8  magnitude of operand 2, unsigned.
REQ-007 sig_2  in  1  sign of operand 2: 1 = negative, 0 = positive.
REQ-008 listo_1  in  1  operand 1 entry complete, level.
REQ-009 listo_2  in  1  operand 2 entry complete, level.
REQ-010 num_mul  out  16  product magnitude, registered.
REQ-011 sig_mul  out  1  product sign, registered.
REQ-012 listo  out  1  product valid, level.
REQ-013 busy  out  1  high while the multiply is iterating.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-015 IDLE -> CALC on the clk edge that samples listo_1=1 and listo_2=1.
- Same edge: latch num_1, num_2, sig_1 ^ sig_2.
- Same edge: clear the 16-bit accumulator and the iteration counter.
REQ-016 CALC SHALL do one radix-2 shift-add step per cycle on the latched operands.
- Step: if the current multiplier bit is 1, add the shifted multiplicand to the accumulator.
- The counter runs 0..7.
REQ-017 CALC -> DONE on the 8th CALC edge.
- The same edge loads num_mul, sets sig_mul and sets listo=1.
- listo is therefore first visible 8 edges after the capture edge.
REQ-018 DONE SHALL hold listo=1 until listo_1=0 or listo_2=0 is sampled.
- Then go to IDLE with listo=0.
- The re-arm rule stops one level-held input pair from re-triggering.
REQ-019 num_mul and sig_mul SHALL keep the last result in IDLE and CALC; they change only on entry to DONE.
REQ-020 Input changes during CALC or DONE SHALL be ignored; only the latched copies are used.
REQ-021 Product width is 16 bits; the maximum 255*255=65025 SHALL be exact, with no truncation.
REQ-022 Zero product (either magnitude 0) SHALL give sig_mul=0; no negative zero.
REQ-023 busy SHALL be 1 exactly in CALC.
REQ-024 listo_1 and listo_2 arriving on different cycles SHALL start only when both are sampled high together.

Reset
REQ-025 On rst=1, immediately and independent of clk:
- state=IDLE, counter=0, accumulator=0;
- num_mul=0, sig_mul=0, listo=0, busy=0.
REQ-026 rst during CALC SHALL abort the operation; no partial result SHALL reach num_mul.
REQ-027 After rst falls, a new start requires both listo inputs sampled high.
- If both are already high, the first clk edge after rst release starts a new operation.

Structure
REQ-028 A shared package SHALL hold:
- the state enum (IDLE, CALC, DONE);
- OP_W=8 and PROD_W=16;
- ITER=8 and the counter width.
REQ-029 A single module SHALL contain FSM, datapath and output registers; no sub-module.

Verification
REQ-030 The bench SHALL cover the following directed scenarios:
- 15(+) x 10(-), both listo high -> 8 edges later listo=1, num_mul=150, sig_mul=1; busy high 8 cycles.
- 255(-) x 255(-) -> num_mul=65025, sig_mul=0.
- 0(-) x 37(+) -> num_mul=0, sig_mul=0.
- rst pulse at the 4th CALC cycle of 12x12 -> all outputs 0 at once; then 3(+) x 4(+) -> num_mul=12, sig_mul=0.
- listo_1/listo_2 held high after a DONE -> no second start. Drop listo_2 -> IDLE, listo=0, num_mul holds. Re-raise listo_2 -> new operation.
- Change num_1 from 15 to 99 during CALC of 15x10 -> result still 150.
